// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Selects ALU / load / link / immediate
//            result, aligns and extends sub-word loads, and issues a
//            registered register-file write. Loads park in WAIT_MEM until
//            memory data arrives, back-pressuring the previous stage.
// Options  : WB_MEM_TIMEOUT_EN - abort a load after MEM_TIMEOUT waiting
//            cycles and raise the sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT    = 16,
   localparam int OFF_W         = $clog2(DATA_WIDTH/8)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
   input  logic                      ctr_reg_write,
   input  logic [1:0]                ctr_wb_sel,
   input  logic [1:0]                ctr_load_size,
   input  logic                      ctr_load_unsigned,
   input  logic [OFF_W-1:0]          byte_offset,
   input  logic [DATA_WIDTH-1:0]     alu,
   input  logic [DATA_WIDTH-1:0]     link,
   input  logic [DATA_WIDTH-1:0]     imm,
   input  logic [DATA_WIDTH-1:0]     datamem,
   input  logic                      datamem_valid,
   output logic [DATA_WIDTH-1:0]     writeback,
   output logic [REG_ADDR_WIDTH-1:0] wb_addr,
   output logic                      wb_we,
   output logic                      stall,
   output logic                      err
);

   localparam logic [1:0] c_sel_mem = 2'b01;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic                      w_accept;
   logic                      w_load_done;

   logic [REG_ADDR_WIDTH-1:0] r_addr;
   logic                      r_reg_write;
   logic [1:0]                r_load_size;
   logic                      r_load_unsigned;
   logic [OFF_W-1:0]          r_offset;

   logic [DATA_WIDTH-1:0]     r_writeback;
   logic [REG_ADDR_WIDTH-1:0] r_wb_addr;
   logic                      r_wb_we;

   logic [DATA_WIDTH-1:0]     w_src;
   logic [7:0]                w_byte;
   logic [15:0]               w_half;
   logic [DATA_WIDTH-1:0]     w_word_ext;
   logic [DATA_WIDTH-1:0]     w_load;

`ifdef WB_MEM_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(MEM_TIMEOUT + 1);
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_err;
   logic               w_timeout;
`endif

   assign in_ready  = enable && (r_state == IDLE);
   assign stall     = (r_state == WAIT_MEM);
   assign writeback = r_writeback;
   assign wb_addr   = r_wb_addr;
   assign wb_we     = r_wb_we;

   // Little-endian lane extraction; the half lane ignores offset bit 0
   assign w_byte = datamem[{r_offset, 3'b000} +: 8];
   assign w_half = datamem[{r_offset[OFF_W-1:1], 4'b0000} +: 16];

   generate
      if (DATA_WIDTH > 32) begin : g_word_wide
         logic [31:0] w_word;
         assign w_word     = datamem[{r_offset[OFF_W-1:2], 5'b00000} +: 32];
         assign w_word_ext = {{(DATA_WIDTH-32){~r_load_unsigned & w_word[31]}}, w_word};
      end else begin : g_word_narrow
         // With a 32-bit datapath a word load is the whole bus
         assign w_word_ext = datamem;
      end
   endgenerate

   // Size select and sign/zero extension of the load lane
   always_comb begin
      w_load = datamem;
      case (r_load_size)
         2'b00:   w_load = {{(DATA_WIDTH-8){~r_load_unsigned & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{(DATA_WIDTH-16){~r_load_unsigned & w_half[15]}}, w_half};
         2'b10:   w_load = w_word_ext;
         default: w_load = datamem;
      endcase
   end

   // Non-load result source multiplexer
   always_comb begin
      w_src = alu;
      case (ctr_wb_sel)
         2'b10:   w_src = link;
         2'b11:   w_src = imm;
         default: w_src = alu;
      endcase
   end

   // Next-state and handshake decode; nothing advances while enable is low
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_load_done  = 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
      w_timeout    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (in_valid && enable) begin
               w_accept = 1'b1;
               if (ctr_wb_sel == c_sel_mem) w_state_next = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (enable) begin
               if (datamem_valid) begin
                  w_load_done  = 1'b1;
                  w_state_next = IDLE;
               end
`ifdef WB_MEM_TIMEOUT_EN
               else if (r_cnt == c_cnt_w'(MEM_TIMEOUT - 1)) begin
                  w_timeout    = 1'b1;
                  w_state_next = IDLE;
               end
`endif
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Capture of instruction fields and registered register-file write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr          <= '0;
         r_reg_write     <= 1'b0;
         r_load_size     <= 2'b00;
         r_load_unsigned <= 1'b0;
         r_offset        <= '0;
         r_writeback     <= '0;
         r_wb_addr       <= '0;
         r_wb_we         <= 1'b0;
      end else begin
         r_wb_we <= 1'b0;
         if (w_accept) begin
            r_addr          <= rd_addr;
            r_reg_write     <= ctr_reg_write;
            r_load_size     <= ctr_load_size;
            r_load_unsigned <= ctr_load_unsigned;
            r_offset        <= byte_offset;
            if (ctr_wb_sel != c_sel_mem) begin
               r_writeback <= w_src;
               r_wb_addr   <= rd_addr;
               r_wb_we     <= ctr_reg_write && (rd_addr != '0);
            end
         end
         if (w_load_done) begin
            r_writeback <= w_load;
            r_wb_addr   <= r_addr;
            r_wb_we     <= r_reg_write && (r_addr != '0);
         end
      end
   end

`ifdef WB_MEM_TIMEOUT_EN
   // Wait-cycle counter and sticky timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept)                               r_cnt <= '0;
         else if ((r_state == WAIT_MEM) && enable)   r_cnt <= r_cnt + 1'b1;
         if (w_timeout)                              r_err <= 1'b1;
      end
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Scoreboard bench for writeback_stage (32-bit datapath).
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  rd_addr = '0;
   logic        ctr_reg_write = 1'b0;
   logic [1:0]  ctr_wb_sel = 2'b00;
   logic [1:0]  ctr_load_size = 2'b00;
   logic        ctr_load_unsigned = 1'b0;
   logic [1:0]  byte_offset = '0;
   logic [31:0] alu = '0, link = '0, imm = '0, datamem = '0;
   logic        datamem_valid = 1'b0;
   logic [31:0] writeback;
   logic [4:0]  wb_addr;
   logic        wb_we, stall, err;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   writeback_stage dut (
      .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
      .in_ready(in_ready), .rd_addr(rd_addr), .ctr_reg_write(ctr_reg_write),
      .ctr_wb_sel(ctr_wb_sel), .ctr_load_size(ctr_load_size),
      .ctr_load_unsigned(ctr_load_unsigned), .byte_offset(byte_offset),
      .alu(alu), .link(link), .imm(imm), .datamem(datamem),
      .datamem_valid(datamem_valid), .writeback(writeback), .wb_addr(wb_addr),
      .wb_we(wb_we), .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   // Present one instruction; unselected sources carry the complement
   task automatic drive_op(input logic [1:0] sel, input logic [1:0] size,
                           input logic uns, input logic [1:0] off,
                           input logic [4:0] rd, input logic we,
                           input logic [31:0] val);
      in_valid          = 1'b1;
      ctr_wb_sel        = sel;
      ctr_load_size     = size;
      ctr_load_unsigned = uns;
      byte_offset       = off;
      rd_addr           = rd;
      ctr_reg_write     = we;
      alu  = (sel == 2'b00) ? val : ~val;
      link = (sel == 2'b10) ? val : ~val;
      imm  = (sel == 2'b11) ? val : ~val;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (writeback !== 32'h0) begin failures++; $display("FAIL reset_wb got=%h exp=0", writeback); end
      checks++; if (wb_addr !== 5'h0)    begin failures++; $display("FAIL reset_addr got=%h exp=0", wb_addr); end
      checks++; if (wb_we !== 1'b0)      begin failures++; $display("FAIL reset_we got=%b exp=0", wb_we); end
      checks++; if (stall !== 1'b0)      begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_alu();
      @(negedge clk);
      drive_op(2'b00, 2'b00, 1'b0, 2'd0, 5'd5, 1'b1, 32'h33333333);
      sb.push_back('{32'h33333333, 5'd5, 1'b1});
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++; if (writeback !== e.data) begin failures++; $display("FAIL alu_wb got=%h exp=%h", writeback, e.data); end
      checks++; if (wb_addr !== e.addr)   begin failures++; $display("FAIL alu_addr got=%0d exp=%0d", wb_addr, e.addr); end
      checks++; if (wb_we !== e.we)       begin failures++; $display("FAIL alu_we got=%b exp=%b", wb_we, e.we); end
      @(negedge clk);
      checks++; if (wb_we !== 1'b0)       begin failures++; $display("FAIL alu_we_pulse got=%b exp=0", wb_we); end
   endtask

   task automatic test_loads();
      logic [1:0]  size_t[4] = '{2'b00, 2'b00, 2'b01, 2'b10};
      logic        uns_t[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0]  off_t[4]  = '{2'd0, 2'd1, 2'd2, 2'd0};
      logic [31:0] exp_t4[4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00008081, 32'h8081FF7F};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_op(2'b01, size_t[i], uns_t[i], off_t[i], 5'd9, 1'b1, 32'hDEADBEEF);
         datamem = 32'h8081FF7F;
         sb.push_back('{exp_t4[i], 5'd9, 1'b1});
         @(negedge clk);
         in_valid = 1'b0;
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL load%0d_ready got=%b exp=0", i, in_ready); end
         checks++; if (wb_we !== 1'b0)    begin failures++; $display("FAIL load%0d_early_we got=%b exp=0", i, wb_we); end
         for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load%0d_stall got=%b exp=1", i, stall); end
         end
         datamem_valid = 1'b1;
         @(negedge clk);
         datamem_valid = 1'b0;
         e = sb.pop_front();
         checks++; if (writeback !== e.data) begin failures++; $display("FAIL load%0d_wb got=%h exp=%h", i, writeback, e.data); end
         checks++; if (wb_we !== e.we || wb_addr !== e.addr) begin failures++; $display("FAIL load%0d_we_addr got=%b/%0d exp=%b/%0d", i, wb_we, wb_addr, e.we, e.addr); end
         checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load%0d_stall_end got=%b exp=0", i, stall); end
      end
   endtask

   task automatic test_suppress_select();
      logic [1:0]  sel_t[4] = '{2'b00, 2'b00, 2'b10, 2'b11};
      logic [4:0]  rd_t[4]  = '{5'd0, 5'd6, 5'd3, 5'd4};
      logic        we_t[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] val_t[4] = '{32'h00001234, 32'h00005678, 32'h00000104, 32'hFFFFF000};
      logic        exp_we[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_op(sel_t[i], 2'b11, 1'b1, 2'd3, rd_t[i], we_t[i], val_t[i]);
         sb.push_back('{val_t[i], rd_t[i], exp_we[i]});
         @(negedge clk);
         in_valid = 1'b0;
         e = sb.pop_front();
         checks++; if (writeback !== e.data) begin failures++; $display("FAIL sel%0d_wb got=%h exp=%h", i, writeback, e.data); end
         checks++; if (wb_we !== e.we || wb_addr !== e.addr) begin failures++; $display("FAIL sel%0d_we_addr got=%b/%0d exp=%b/%0d", i, wb_we, wb_addr, e.we, e.addr); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      @(negedge clk);
      drive_op(2'b00, 2'b00, 1'b0, 2'd0, 5'd10, 1'b1, 32'hA0000000);
      sb.push_back('{32'hA0000000, 5'd10, 1'b1});
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (wb_we !== e.we || writeback !== e.data || wb_addr !== e.addr) begin
            failures++; $display("FAIL b2b%0d got=%b/%h/%0d exp=%b/%h/%0d", i, wb_we, writeback, wb_addr, e.we, e.data, e.addr);
         end
         if (i < 3) begin
            v = 32'hA0000000 + i;
            drive_op((i == 1) ? 2'b11 : 2'b10, 2'b00, 1'b0, 2'd0, 5'(10 + i), 1'b1, v);
            sb.push_back('{v, 5'(10 + i), 1'b1});
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_enable_freeze();
      @(negedge clk);
      drive_op(2'b01, 2'b10, 1'b0, 2'd0, 5'd7, 1'b1, 32'h0);
      datamem = 32'h11223344;
      sb.push_back('{32'h11223344, 5'd7, 1'b1});
      @(negedge clk);
      in_valid = 1'b0;
      enable = 1'b0;
      datamem_valid = 1'b1;
      for (int w = 0; w < 2; w++) begin
         @(negedge clk);
         checks++; if (wb_we !== 1'b0 || in_ready !== 1'b0 || stall !== 1'b1) begin
            failures++; $display("FAIL freeze%0d we/ready/stall got=%b/%b/%b exp=0/0/1", w, wb_we, in_ready, stall);
         end
      end
      enable = 1'b1;
      @(negedge clk);
      datamem_valid = 1'b0;
      e = sb.pop_front();
      checks++; if (wb_we !== e.we || writeback !== e.data || wb_addr !== e.addr) begin
         failures++; $display("FAIL freeze_release got=%b/%h/%0d exp=%b/%h/%0d", wb_we, writeback, wb_addr, e.we, e.data, e.addr);
      end
   endtask

   task automatic test_reset_midload();
      @(negedge clk);
      drive_op(2'b01, 2'b10, 1'b0, 2'd0, 5'd8, 1'b1, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL midload_stall got=%b exp=1", stall); end
      #2 reset = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL midload_reset stall/we got=%b/%b exp=0/0", stall, wb_we); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || wb_we !== 1'b0) begin failures++; $display("FAIL midload_after ready/we got=%b/%b exp=1/0", in_ready, wb_we); end
      datamem_valid = 1'b1;
      @(negedge clk);
      datamem_valid = 1'b0;
      checks++; if (wb_we !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL idle_datamem we/stall got=%b/%b exp=0/0", wb_we, stall); end
   endtask

`ifdef WB_MEM_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge clk);
      drive_op(2'b01, 2'b10, 1'b0, 2'd0, 5'd12, 1'b1, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
      checks++; if (err !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL tmo_early err/stall got=%b/%b exp=0/1", err, stall); end
      @(negedge clk);
      checks++; if (err !== 1'b1 || stall !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL tmo err/stall/we got=%b/%b/%b exp=1/0/0", err, stall, wb_we); end
      drive_op(2'b00, 2'b00, 1'b0, 2'd0, 5'd13, 1'b1, 32'h0BADF00D);
      sb.push_back('{32'h0BADF00D, 5'd13, 1'b1});
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++; if (wb_we !== e.we || writeback !== e.data || err !== 1'b1) begin
         failures++; $display("FAIL tmo_after we/wb/err got=%b/%h/%b exp=%b/%h/1", wb_we, writeback, err, e.we, e.data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_suppress_select();
      test_back_to_back();
      test_enable_freeze();
      test_reset_midload();
`ifdef WB_MEM_TIMEOUT_EN
      test_timeout();
`else
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_tied got=%b exp=0", err); end
`endif
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
